// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: PC/ALU selects, hazard FSM states, forwarding codes.
// Used by hazard_ctrl and hazard_fwd_unit (build option HAZARD_FORWARD_EN).
package hazard_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_JR     = 2'd3;

    localparam logic [2:0] ALU_SEL_ADD = 3'd0;
    localparam logic [2:0] ALU_SEL_SUB = 3'd1;
    localparam logic [2:0] ALU_SEL_AND = 3'd2;
    localparam logic [2:0] ALU_SEL_OR  = 3'd3;
    localparam logic [2:0] ALU_SEL_SLT = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // $0 is hard-wired, so it never produces a hazard or forwarded value.
    function automatic logic src_match(input logic [4:0] src, input logic used,
                                       input logic [4:0] dst, input logic we);
        return used && we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational register-match logic: forwarding selects and stall request.
// HAZARD_FORWARD_EN selects forwarding + load-use stall; otherwise RAW stall only.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_reg_write,
    input  logic       mem_reg_write,
    input  logic       wb_reg_write,
    input  logic       ex_mem_read,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall_hit
);

`ifdef HAZARD_FORWARD_EN
    // The newest producer (EX/MEM) wins over the older one (MEM/WB).
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (src_match(id_rs, 1'b1, mem_rd, mem_reg_write))
            fwd_a = FWD_EXMEM;
        else if (src_match(id_rs, 1'b1, wb_rd, wb_reg_write))
            fwd_a = FWD_MEMWB;
        if (src_match(id_rt, 1'b1, mem_rd, mem_reg_write))
            fwd_b = FWD_EXMEM;
        else if (src_match(id_rt, 1'b1, wb_rd, wb_reg_write))
            fwd_b = FWD_MEMWB;
    end

    assign stall_hit = ex_mem_read &&
                       (src_match(id_rs, id_use_rs, ex_rd, ex_reg_write) ||
                        src_match(id_rt, id_use_rt, ex_rd, ex_reg_write));
`else
    logic unused_in;

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    // Register file is write-first, so a WB producer never needs a stall.
    assign stall_hit = src_match(id_rs, id_use_rs, ex_rd,  ex_reg_write)  ||
                       src_match(id_rt, id_use_rt, ex_rd,  ex_reg_write)  ||
                       src_match(id_rs, id_use_rs, mem_rd, mem_reg_write) ||
                       src_match(id_rt, id_use_rt, mem_rd, mem_reg_write);
    assign unused_in = ^{wb_rd, wb_reg_write, ex_mem_read};
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: cycle classification, stage enables/flushes, stall and
// memory-wait counters. Build option HAZARD_FORWARD_EN enables operand forwarding.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_reg_write,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state_reg, state_next, cycle_class;
    logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [1:0]        fwd_a_raw, fwd_b_raw;
    logic              stall_hit, stall_ok, wait_cond, timeout;

    hazard_fwd_unit u_fwd (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .ex_rd         (ex_rd),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .ex_mem_read   (ex_mem_read),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw),
        .stall_hit     (stall_hit)
    );

`ifdef HAZARD_FORWARD_EN
    // The load has moved on after one bubble, so a load-use stall never repeats.
    assign stall_ok = (state_reg != ST_STALL);
`else
    assign stall_ok = 1'b1;
`endif

    assign wait_cond = dmem_req && !dmem_ack;
    assign timeout   = (wait_cnt_reg == WCNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        cycle_class   = ST_RUN;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_flush   = 1'b0;
        fwd_a         = fwd_a_raw;
        fwd_b         = fwd_b_raw;
        mem_err       = 1'b0;
        wait_cnt_next = '0;

        if (wait_cond) begin
            cycle_class = ST_MEM_WAIT;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            if (timeout)
                mem_err = 1'b1;
            else
                wait_cnt_next = wait_cnt_reg + 1'b1;
        end else if (ex_redirect) begin
            cycle_class = ST_FLUSH;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (stall_hit && stall_ok) begin
            cycle_class = ST_STALL;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end

        // A timed-out wait gives the pipeline one RUN cycle before re-entering.
        state_next = (wait_cond && timeout) ? ST_RUN : cycle_class;

        stall_cnt_next = stall_cnt_reg;
        if (cycle_class != ST_RUN && stall_cnt_reg != {CNT_W{1'b1}})
            stall_cnt_next = stall_cnt_reg + 1'b1;

        if (!reset) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            memwb_flush = 1'b0;
            fwd_a       = FWD_REG;
            fwd_b       = FWD_REG;
            mem_err     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign state     = state_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt;
    logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
    logic       ex_redirect, dmem_req, dmem_ack;
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b, state;
    logic [3:0] stall_cnt;
    logic       mem_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0; ex_mem_read = 0;
        ex_redirect = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic load_use_8;
        ex_rd = 8; ex_reg_write = 1; ex_mem_read = 1;
        id_rs = 8; id_use_rs = 1;
    endtask

    initial begin
        // reset held while hazards are present
        idle();
        reset = 0;
        ex_redirect = 1; dmem_req = 1;
        load_use_8();
        mem_rd = 8; mem_reg_write = 1;
        #3;
        $display("step reset_hold");
        check("rst_pc_en", pc_en, 1);
        check("rst_exmem_en", exmem_en, 1);
        check("rst_ifid_flush", ifid_flush, 0);
        check("rst_memwb_flush", memwb_flush, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_state", state, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_mem_err", mem_err, 0);
        tick();
        check("rst_state_held", state, 0);
        idle();
        @(negedge clk) reset = 1;
        tick();
        check("run_state", state, 0);

        // load-use: lw $8 in EX, ID reads $8
        $display("step load_use");
        load_use_8();
        #1;
        check("lu_pc_en", pc_en, 0);
        check("lu_ifid_en", ifid_en, 0);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_idex_en", idex_en, 1);
        check("lu_ifid_flush", ifid_flush, 0);
        tick(); exp_cnt += 1;
        check("lu_state", state, 1);
        check("lu_stall_cnt", stall_cnt, exp_cnt);
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 8; mem_reg_write = 1;
        #1;
        check("lu_adv_pc_en", pc_en, FWD ? 1 : 0);
        check("lu_adv_fwd_a", fwd_a, FWD ? 1 : 0);
        tick(); exp_cnt += FWD ? 0 : 1;
        check("lu_adv_state", state, FWD ? 0 : 1);
        check("lu_adv_stall_cnt", stall_cnt, exp_cnt);
        idle();
        tick();
        check("lu_end_state", state, 0);

        // forwarding selects within one cycle
        $display("step forwarding");
        id_rs = 9; id_rt = 9; id_use_rs = 1; id_use_rt = 1;
        mem_rd = 9; mem_reg_write = 1; wb_rd = 9; wb_reg_write = 1;
        #1;
        check("fw_mem_fwd_a", fwd_a, FWD ? 1 : 0);
        check("fw_mem_fwd_b", fwd_b, FWD ? 1 : 0);
        check("fw_mem_pc_en", pc_en, FWD ? 1 : 0);
        mem_reg_write = 0;
        #1;
        check("fw_wb_fwd_a", fwd_a, FWD ? 2 : 0);
        check("fw_wb_pc_en", pc_en, 1);
        mem_rd = 0; mem_reg_write = 1; wb_rd = 0;
        #1;
        check("fw_r0_fwd_a", fwd_a, 0);
        check("fw_r0_pc_en", pc_en, 1);
        idle();
        tick();
        check("fw_state", state, 0);

        // add $9 walks EX -> MEM -> WB while ID reads $9
        $display("step raw_alu");
        ex_rd = 9; ex_reg_write = 1; id_rs = 9; id_use_rs = 1;
        #1;
        check("raw_ex_pc_en", pc_en, FWD ? 1 : 0);
        check("raw_ex_fwd_a", fwd_a, 0);
        tick(); exp_cnt += FWD ? 0 : 1;
        ex_rd = 0; ex_reg_write = 0; mem_rd = 9; mem_reg_write = 1;
        #1;
        check("raw_mem_pc_en", pc_en, FWD ? 1 : 0);
        check("raw_mem_fwd_a", fwd_a, FWD ? 1 : 0);
        tick(); exp_cnt += FWD ? 0 : 1;
        check("raw_stall_cnt", stall_cnt, exp_cnt);
        mem_rd = 0; mem_reg_write = 0; wb_rd = 9; wb_reg_write = 1;
        #1;
        check("raw_wb_pc_en", pc_en, 1);
        check("raw_wb_fwd_a", fwd_a, FWD ? 2 : 0);
        idle();
        tick();
        check("raw_state", state, 0);

        // taken branch in EX with a concurrent load-use hit
        $display("step redirect");
        load_use_8();
        ex_redirect = 1;
        #1;
        check("rd_ifid_flush", ifid_flush, 1);
        check("rd_idex_flush", idex_flush, 1);
        check("rd_pc_en", pc_en, 1);
        check("rd_ifid_en", ifid_en, 1);
        check("rd_memwb_flush", memwb_flush, 0);
        tick(); exp_cnt += 1;
        check("rd_state", state, 2);
        check("rd_stall_cnt", stall_cnt, exp_cnt);
        idle();
        tick();
        check("rd_end_state", state, 0);

        // zero-wait memory access
        $display("step zero_wait");
        dmem_req = 1; dmem_ack = 1;
        #1;
        check("zw_pc_en", pc_en, 1);
        check("zw_memwb_flush", memwb_flush, 0);
        tick();
        check("zw_state", state, 0);

        // three wait cycles, first one also carrying a redirect
        $display("step mem_wait");
        dmem_req = 1; dmem_ack = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_pc_en", pc_en, 0);
            check("mw_exmem_en", exmem_en, 0);
            check("mw_memwb_flush", memwb_flush, 1);
            check("mw_ifid_flush", ifid_flush, 0);
            check("mw_mem_err", mem_err, 0);
            tick(); exp_cnt += 1;
            ex_redirect = 0;
        end
        check("mw_state", state, 3);
        check("mw_stall_cnt", stall_cnt, exp_cnt);
        dmem_ack = 1;
        #1;
        check("mw_ack_pc_en", pc_en, 1);
        check("mw_ack_memwb_flush", memwb_flush, 0);
        tick();
        check("mw_ack_state", state, 0);
        idle();

        // ack never arrives: pulse on the 4th wait cycle, then one RUN cycle
        $display("step timeout");
        dmem_req = 1; dmem_ack = 0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("to_mem_err", mem_err, (i == 4) ? 1 : 0);
            tick(); exp_cnt += 1;
            check("to_state", state, (i == 4) ? 0 : 3);
        end
        idle();
        tick();
        check("to_end_state", state, 0);
        check("to_stall_cnt", stall_cnt, exp_cnt);

        // reset asserted in the middle of a memory wait
        $display("step reset_mid_wait");
        dmem_req = 1; dmem_ack = 0;
        tick();
        check("rm_state_before", state, 3);
        #1 reset = 0;
        #1;
        check("rm_state", state, 0);
        check("rm_stall_cnt", stall_cnt, 0);
        check("rm_pc_en", pc_en, 1);
        check("rm_memwb_flush", memwb_flush, 0);
        idle();
        @(negedge clk) reset = 1;
        tick();
        check("rm_after_state", state, 0);
        check("rm_after_stall_cnt", stall_cnt, 0);

        // stall counter saturates at all-ones
        $display("step saturate");
        dmem_req = 1; dmem_ack = 0;
        for (int i = 0; i < 19; i++) tick();
        check("sat_stall_cnt", stall_cnt, 15);
        check("sat_state", state, 3);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
